// File: rtl/bridge_pkg.sv
// Shared definitions for the AHB-to-APB bridge: APB master states, AHB
// transfer/burst encodings and default bus widths.
package bridge_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HBURST_INCR   = 3'b001;
   localparam logic [2:0] HBURST_WRAP4  = 3'b010;
   localparam logic [2:0] HBURST_INCR4  = 3'b011;
   localparam logic [2:0] HBURST_WRAP8  = 3'b100;
   localparam logic [2:0] HBURST_INCR8  = 3'b101;
   localparam logic [2:0] HBURST_WRAP16 = 3'b110;
   localparam logic [2:0] HBURST_INCR16 = 3'b111;

   // Wait counter width; a disabled timeout still gets one bit.
   function automatic int cnt_width(input int timeout);
      return (timeout < 1) ? 1 : $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/bridge_req_fifo.sv
// Request buffer between the AHB-side latch and the APB master. Exposes the
// head entry and the entry that will be head after the next pop.
module bridge_req_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 65
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push_i,
   input  logic                         pop_i,
   input  logic [W-1:0]                 wr_data_i,
   output logic [W-1:0]                 head_o,
   output logic [W-1:0]                 next_head_o,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CW    = $clog2(DEPTH + 1);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             push_ok;
   logic             pop_ok;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_q] <= wr_data_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   assign head_o = mem[rd_ptr_q];
   // With a single entry left, the successor is whatever is being pushed now.
   assign next_head_o = (count_q > CW'(1)) ? mem[rd_ptr_q + PTR_W'(1)] : wr_data_i;

endmodule

// File: rtl/apb_master_fsm.sv
// APB master stage of the AHB-to-APB bridge: buffers AHB-side requests and
// runs SETUP/ACCESS for each, returning read data and error pulses.
module apb_master_fsm
   import bridge_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int FIFO_DEPTH = 2,
   parameter int TIMEOUT    = 16
) (
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic              VALID,
   input  logic [ADDR_W-1:0] HADDR_TEMP,
   input  logic [DATA_W-1:0] HWDATA_TEMP,
   input  logic              HWRITE_TEMP,
   output logic              HREADYOUT,
   output logic [DATA_W-1:0] HRDATA,
   output logic              RDVALID,
   output logic              HRESP,
   output logic              PSEL,
   output logic              PENABLE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   output logic              PWRITE,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PREADY,
   input  logic              PSLVERR
);

   localparam int ENT_W  = ADDR_W + DATA_W + 1;
   localparam int CNT_W  = cnt_width(TIMEOUT);
   localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   apb_state_e        state_q;
   logic [CNT_W-1:0]  wait_cnt_q;
   logic              psel_q;
   logic              penable_q;
   logic              pwrite_q;
   logic [ADDR_W-1:0] paddr_q;
   logic [DATA_W-1:0] pwdata_q;
   logic [DATA_W-1:0] hrdata_q;
   logic              rdvalid_q;
   logic              hresp_q;

   logic [ENT_W-1:0]  fifo_head;
   logic [ENT_W-1:0]  fifo_next;
   logic              fifo_full;
   logic              fifo_empty;
   logic [FCNT_W-1:0] fifo_count;
   logic              fifo_push;
   logic              fifo_pop;
   logic              timeout_hit;
   logic              more_after_pop;

   assign HREADYOUT      = !fifo_full;
   assign fifo_push      = VALID && HREADYOUT;
   assign timeout_hit    = (TIMEOUT != 0) && !PREADY && (wait_cnt_q == TO_LAST);
   assign fifo_pop       = (state_q == ACCESS) && (PREADY || timeout_hit);
   assign more_after_pop = (fifo_count > FCNT_W'(1)) || fifo_push;

   bridge_req_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (ENT_W)
   ) u_req_fifo (
      .clk         (HCLK),
      .rst         (HRESET),
      .push_i      (fifo_push),
      .pop_i       (fifo_pop),
      .wr_data_i   ({HADDR_TEMP, HWDATA_TEMP, HWRITE_TEMP}),
      .head_o      (fifo_head),
      .next_head_o (fifo_next),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count)
   );

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state_q    <= IDLE;
         wait_cnt_q <= '0;
         psel_q     <= 1'b0;
         penable_q  <= 1'b0;
         pwrite_q   <= 1'b0;
         paddr_q    <= '0;
         pwdata_q   <= '0;
         hrdata_q   <= '0;
         rdvalid_q  <= 1'b0;
         hresp_q    <= 1'b0;
      end else begin
         rdvalid_q <= 1'b0;
         hresp_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!fifo_empty) begin
                  {paddr_q, pwdata_q, pwrite_q} <= fifo_head;
                  psel_q    <= 1'b1;
                  penable_q <= 1'b0;
                  state_q   <= SETUP;
               end
            end
            SETUP: begin
               penable_q  <= 1'b1;
               wait_cnt_q <= '0;
               state_q    <= ACCESS;
            end
            ACCESS: begin
               if (PREADY) begin
                  if (PSLVERR) begin
                     hresp_q <= 1'b1;
                  end else if (!pwrite_q) begin
                     hrdata_q  <= PRDATA;
                     rdvalid_q <= 1'b1;
                  end
                  penable_q <= 1'b0;
                  if (more_after_pop) begin
                     {paddr_q, pwdata_q, pwrite_q} <= fifo_next;
                     state_q <= SETUP;
                  end else begin
                     psel_q  <= 1'b0;
                     state_q <= IDLE;
                  end
               end else if (timeout_hit) begin
                  hresp_q   <= 1'b1;
                  psel_q    <= 1'b0;
                  penable_q <= 1'b0;
                  state_q   <= IDLE;
               end else if (wait_cnt_q != CNT_SAT) begin
                  wait_cnt_q <= wait_cnt_q + CNT_W'(1);
               end
            end
            default: begin
               psel_q    <= 1'b0;
               penable_q <= 1'b0;
               state_q   <= IDLE;
            end
         endcase
      end
   end

   assign PSEL    = psel_q;
   assign PENABLE = penable_q;
   assign PWRITE  = pwrite_q;
   assign PADDR   = paddr_q;
   assign PWDATA  = pwdata_q;
   assign HRDATA  = hrdata_q;
   assign RDVALID = rdvalid_q;
   assign HRESP   = hresp_q;

endmodule

// File: doc/apb_master_fsm.md
# apb_master_fsm

Downstream stage of the AHB slave interface in the AHB-to-APB bridge. Accepts the latched transfer (address, write data, direction, valid) produced by the AHB side and buffers it in a small request FIFO. Drives the APB SETUP/ACCESS protocol for each request, returns read data and error status toward the AHB side, and back-pressures the AHB side through HREADYOUT.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- FIFO_DEPTH, 2, request buffer entries; power of two, ≥2
- TIMEOUT, 16, max ACCESS cycles with PREADY low before abort; 0 disables
- HCLK  in  1  clock, all logic on rising edge
- HRESET  in  1  reset; one clock, asynchronous, active-high
- VALID  in  1  AHB-side request valid
- HADDR_TEMP  in  ADDR_W  request address
- HWDATA_TEMP  in  DATA_W  request write data
- HWRITE_TEMP  in  1  1=write, 0=read
- HREADYOUT  out  1  request can be accepted this cycle
- HRDATA  out  DATA_W  read data of last completed read
- RDVALID  out  1  one-cycle pulse: HRDATA updated
- HRESP  out  1  one-cycle pulse: transfer ended in error
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PWRITE  out  1  APB direction
- PRDATA  in  DATA_W  APB read data
- PREADY  in  1  APB slave ready
- PSLVERR  in  1  APB slave error

## Operation
- Reset values: PSEL, PENABLE, PWRITE, RDVALID, HRESP = 0; PADDR, PWDATA, HRDATA = 0; HREADYOUT = 1; FIFO empty; state IDLE; wait counter 0.
- Accept: request pushed at a rising edge where VALID && HREADYOUT. HREADYOUT = !full, from registered FIFO count only. VALID while HREADYOUT=0 is ignored; upstream holds.
- States: IDLE, SETUP, ACCESS.
  - IDLE: FIFO non-empty -> SETUP; PADDR/PWDATA/PWRITE loaded from head, PSEL=1, PENABLE=0.
  - SETUP: unconditionally -> ACCESS; PENABLE=1, wait counter cleared.
  - ACCESS, PREADY=1: head popped. Read: HRDATA<=PRDATA, RDVALID pulse. PSLVERR=1: HRESP pulse; HRDATA not updated; no RDVALID. Next: SETUP with the new head if FIFO still non-empty after pop (push in the same cycle counts), else IDLE with PSEL=PENABLE=0.
  - ACCESS, PREADY=0: stay; PADDR/PWDATA/PWRITE/PSEL/PENABLE stable; counter +1. With TIMEOUT≠0 and counter==TIMEOUT-1: abort, pop, HRESP pulse, -> IDLE.
- Push and pop in the same cycle are legal; count unchanged.
- PWDATA is don't-care on reads; driven from the entry regardless.

## Timing
- Empty FIFO, IDLE: VALID accepted at edge N -> PSEL=1 after edge N+1 -> PENABLE=1 after N+2 -> earliest completion at edge N+3 (PREADY high) -> RDVALID/HRESP high for the cycle after N+3.
- Back-to-back: PSEL stays high; one SETUP cycle between ACCESS phases; no IDLE gap.
- Full FIFO: HREADYOUT low for the whole cycle; returns high the cycle after a pop.
- HRESET asserted mid-transfer: all outputs go to reset values immediately; in-flight and buffered requests are discarded with no HRESP.
- Wait counter width: clog2(TIMEOUT+1); saturates, never wraps.

## Structure
- Shared package bridge_pkg: state enum {IDLE, SETUP, ACCESS}; HTRANS and HBURST encodings shared with the AHB slave; default ADDR_W/DATA_W.
- Sub-module bridge_req_fifo: synchronous FIFO, FIFO_DEPTH × (ADDR_W+DATA_W+1), push/pop/full/empty/count, same async active-high reset, pointers wrap modulo FIFO_DEPTH.

## Test plan
- Single write 0x0000_0010/0xDEAD_BEEF, PREADY=1 -> PSEL at N+1, PENABLE at N+2, PADDR=0x10, PWDATA=0xDEADBEEF, PWRITE=1, no RDVALID/HRESP.
- Read 0x20, PREADY low 3 cycles, then high with PRDATA=0x1234_5678 -> PADDR held stable, HRDATA=0x12345678, one RDVALID pulse.
- Three writes on consecutive cycles, PREADY=1 -> HREADYOUT low after two pushes, third held and accepted after first pop, three APB transfers with PSEL continuous.
- Read with PREADY=1, PSLVERR=1 -> one HRESP pulse, HRDATA unchanged, no RDVALID.
- TIMEOUT=4, PREADY stuck low -> abort after 4 ACCESS cycles, HRESP pulse, PSEL=0, FIFO entry removed.
- HRESET asserted during ACCESS with 2 entries buffered -> PSEL/PENABLE=0 immediately, HREADYOUT=1, no transfers after release until new VALID.
